memoria_juego_fsm: RTL
======================

Name: memoria_juego_fsm

Overview:
- Game-logic stage for the 4x4 memory (pairs) game, directly upstream of the VGA controller.
- Owns the board contents (MatrizJuego), the per-card open flags (OpenCards), the cursor (X, Y) and the game result.
- Consumes debounced single-cycle button pulses and runs shuffle, pick, compare, hold and end-of-game sequencing.
- All outputs are registered and feed the VGA controller with the same names and shapes.

Parameters:
- SWAPS, 64: random cell swaps performed per shuffle; 0 leaves the canonical layout (test use).
- HOLD_CYCLES, 25000000: cycles a mismatched pair stays visible (1 s at 25 MHz); minimum 1.
- MAX_MISSES, 12: mismatches allowed; reaching it ends the game as a loss; 1..255.
- LFSR_SEED, 16'hACE1: non-zero reset seed of the 16-bit Fibonacci LFSR (taps 16,14,13,11).

Ports:
- clock_25  in  1  pixel/system clock, 25 MHz.
- reset  in  1  asynchronous, active-low reset.
- btn_up, btn_down, btn_left, btn_right  in  1 each  one-cycle move pulses.
- btn_select  in  1  one-cycle select/restart pulse.
- OpenCards  out  [0:3][0:3] x 1  1 = card face shown; index [row][col].
- MatrizJuego  out  [0:3][0:3] x 5  card value 0..7, upper bits 0.
- X  out  2  cursor column.
- Y  out  2  cursor row.
- result  out  2  00 playing, 01 win, 10 loss, 11 shuffling.
- busy  out  1  high in SHUFFLE and HOLD (inputs ignored).

Behaviour:
- Reset (async assert, sync release):
  - MatrizJuego loaded row-major 0,0,1,1,...,7,7.
  - OpenCards all 0; X=Y=0; miss and pair counters 0; LFSR=LFSR_SEED.
  - State SHUFFLE; result=11; busy=1.
- LFSR advances every cycle in every state; it is never reseeded except by reset.
- SHUFFLE:
  - Each cycle swaps cells LFSR[3:0] and LFSR[7:4]; equal indices are a no-op.
  - Exactly SWAPS cycles, then PICK1. With SWAPS=0, PICK1 is entered on the first cycle after reset release.
  - On entering PICK1: result=00, busy=0.
- Cursor (PICK1/PICK2 only):
  - At most one move per cycle; priority up > down > left > right.
  - Up: Y-1; down: Y+1; left: X-1; right: X+1; all modulo 4 (3 wraps to 0, 0 wraps to 3).
  - Move visible the cycle after the pulse.
- Select (PICK1/PICK2 only):
  - Ignored in any cycle that has a move pulse.
  - Ignored if OpenCards[Y][X]=1.
- PICK1: valid select sets OpenCards[Y][X], latches position A, goes to PICK2.
- PICK2: valid select sets OpenCards[Y][X], latches position B, goes to CHECK.
- CHECK (one cycle):
  - Values equal: pairs+1. If pairs becomes 8, go to WIN; else go to PICK1. Both cards stay open.
  - Values differ: misses+1, go to HOLD.
- HOLD:
  - Counts HOLD_CYCLES cycles, then clears OpenCards at A and B.
  - If misses = MAX_MISSES, go to LOSE; else go to PICK1.
  - busy=1 throughout; all buttons ignored.
- WIN: result=01. LOSE: result=10; all OpenCards set to 1 on entry to reveal the board.
- WIN/LOSE restart on btn_select:
  - Clear OpenCards and counters, keep MatrizJuego and cursor, go to SHUFFLE (result=11).
  - The new shuffle continues from the current LFSR state.
- Reset mid-HOLD or mid-SHUFFLE returns to the reset state immediately; there is no partial completion.
- MatrizJuego changes only in SHUFFLE, so the board always holds each value 0..7 exactly twice.

Test Plan:
- SWAPS=0: reset low 3 cycles then high → result=11 for one cycle, then 00. MatrizJuego[0][0]=0, [0][1]=0, [3][3]=7. X=Y=0, OpenCards all 0.
- Cursor wrap: btn_left at X=0 → X=3; btn_up at Y=0 → Y=3. btn_up+btn_right in the same cycle → only Y changes. Move+select in one cycle → no card opens.
- Match (SWAPS=0): select (0,0), then move right, select (0,1) → [0][0] and [0][1] remain 1, result=00, busy never asserted. Reselect (0,0) → ignored, state stays PICK1.
- Mismatch (HOLD_CYCLES=4): select (0,0) then (0,2) → busy=1 for 4 cycles with both open, then both 0 and busy=0. Buttons during HOLD have no effect.
- Loss (MAX_MISSES=2, HOLD_CYCLES=4): two mismatches → result=10, OpenCards all 1. btn_select → result=11, OpenCards all 0, board remains a permutation of {0..7}x2.
- Win (SWAPS=0): open all eight adjacent pairs → result=01 after the 8th CHECK. Reset asserted mid-game → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/memoria_juego_fsm.sv
// Game logic for the 4x4 memory game: shuffle, pick, compare, hold and end-of-game sequencing.
// All outputs registered (1-cycle latency from button pulse); no backpressure, inputs ignored while busy.
module memoria_juego_fsm #(
    parameter int          SWAPS       = 64,
    parameter int          HOLD_CYCLES = 25000000,
    parameter int          MAX_MISSES  = 12,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clock_25,
    input  logic                  reset,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_select,
    output logic [0:3][0:3]       OpenCards,
    output logic [0:3][0:3][4:0]  MatrizJuego,
    output logic [1:0]            X,
    output logic [1:0]            Y,
    output logic [1:0]            result,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_SHUFFLE,
        ST_PICK1,
        ST_PICK2,
        ST_CHECK,
        ST_HOLD,
        ST_WIN,
        ST_LOSE
    } state_t;

    localparam logic [31:0] SWAPS_L   = SWAPS;
    localparam logic [31:0] HOLD_LAST = HOLD_CYCLES - 1;
    localparam logic [7:0]  MAX_L     = 8'(MAX_MISSES);

    state_t                 state_q, state_d;
    logic [0:3][0:3][4:0]   mat_q, mat_d;
    logic [0:3][0:3]        open_q, open_d;
    logic [1:0]             x_q, x_d, y_q, y_d;
    logic [3:0]             pos_a_q, pos_a_d, pos_b_q, pos_b_d;
    logic [3:0]             pairs_q, pairs_d;
    logic [7:0]             misses_q, misses_d;
    logic [31:0]            shuf_cnt_q, shuf_cnt_d;
    logic [31:0]            hold_cnt_q, hold_cnt_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [1:0]             result_q, result_d;
    logic                   busy_q, busy_d;

    logic                   move;
    logic                   sel_ok;

    function automatic logic [0:3][0:3][4:0] canonical_board();
        logic [0:3][0:3][4:0] b;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                b[r][c] = 5'((r * 4 + c) / 2);
            end
        end
        return b;
    endfunction

    always_comb begin
        state_d    = state_q;
        mat_d      = mat_q;
        open_d     = open_q;
        x_d        = x_q;
        y_d        = y_q;
        pos_a_d    = pos_a_q;
        pos_b_d    = pos_b_q;
        pairs_d    = pairs_q;
        misses_d   = misses_q;
        shuf_cnt_d = shuf_cnt_q;
        hold_cnt_d = hold_cnt_q;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        move   = btn_up | btn_down | btn_left | btn_right;
        sel_ok = btn_select && !move && !open_q[y_q][x_q];

        case (state_q)
            ST_SHUFFLE: begin
                if (shuf_cnt_q == SWAPS_L) begin
                    state_d = ST_PICK1;
                end else begin
                    // Second write restores the cell when both indices coincide.
                    mat_d[lfsr_q[3:2]][lfsr_q[1:0]] = mat_q[lfsr_q[7:6]][lfsr_q[5:4]];
                    mat_d[lfsr_q[7:6]][lfsr_q[5:4]] = mat_q[lfsr_q[3:2]][lfsr_q[1:0]];
                    shuf_cnt_d = shuf_cnt_q + 32'd1;
                end
            end
            ST_PICK1, ST_PICK2: begin
                if (btn_up)         y_d = y_q - 2'd1;
                else if (btn_down)  y_d = y_q + 2'd1;
                else if (btn_left)  x_d = x_q - 2'd1;
                else if (btn_right) x_d = x_q + 2'd1;
                if (sel_ok) begin
                    open_d[y_q][x_q] = 1'b1;
                    if (state_q == ST_PICK1) begin
                        pos_a_d = {y_q, x_q};
                        state_d = ST_PICK2;
                    end else begin
                        pos_b_d = {y_q, x_q};
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (mat_q[pos_a_q[3:2]][pos_a_q[1:0]] == mat_q[pos_b_q[3:2]][pos_b_q[1:0]]) begin
                    pairs_d = pairs_q + 4'd1;
                    state_d = (pairs_q == 4'd7) ? ST_WIN : ST_PICK1;
                end else begin
                    misses_d   = misses_q + 8'd1;
                    hold_cnt_d = 32'd0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    open_d[pos_a_q[3:2]][pos_a_q[1:0]] = 1'b0;
                    open_d[pos_b_q[3:2]][pos_b_q[1:0]] = 1'b0;
                    if (misses_q == MAX_L) begin
                        open_d  = '1;
                        state_d = ST_LOSE;
                    end else begin
                        state_d = ST_PICK1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (btn_select) begin
                    open_d     = '0;
                    pairs_d    = 4'd0;
                    misses_d   = 8'd0;
                    shuf_cnt_d = 32'd0;
                    state_d    = ST_SHUFFLE;
                end
            end
            default: state_d = ST_SHUFFLE;
        endcase

        case (state_d)
            ST_SHUFFLE: result_d = 2'b11;
            ST_WIN:     result_d = 2'b01;
            ST_LOSE:    result_d = 2'b10;
            default:    result_d = 2'b00;
        endcase
        busy_d = (state_d == ST_SHUFFLE) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_SHUFFLE;
            mat_q      <= canonical_board();
            open_q     <= '0;
            x_q        <= 2'd0;
            y_q        <= 2'd0;
            pos_a_q    <= 4'd0;
            pos_b_q    <= 4'd0;
            pairs_q    <= 4'd0;
            misses_q   <= 8'd0;
            shuf_cnt_q <= 32'd0;
            hold_cnt_q <= 32'd0;
            lfsr_q     <= LFSR_SEED;
            result_q   <= 2'b11;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            mat_q      <= mat_d;
            open_q     <= open_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pos_a_q    <= pos_a_d;
            pos_b_q    <= pos_b_d;
            pairs_q    <= pairs_d;
            misses_q   <= misses_d;
            shuf_cnt_q <= shuf_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            lfsr_q     <= lfsr_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
        end
    end

    assign OpenCards   = open_q;
    assign MatrizJuego = mat_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign result      = result_q;
    assign busy        = busy_q;

endmodule
